// File: rtl/defines_package.sv
// Shared rasterizer types: coordinate width and 2-D point.
package defines_package;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } Point2D;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bresenham_line.sv
// Bresenham line walker: emits every pixel from p to q inclusive over a
// valid/ready handshake, then pulses done for one cycle.
module bresenham_line
    import defines_package::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   start,
    input  Point2D p,
    input  Point2D q,
    output Point2D pixel,
    output logic   pixel_valid,
    input  logic   pixel_ready,
    output logic   busy,
    output logic   done
);

    localparam int EW  = COORD_W + 2;
    localparam int E2W = COORD_W + 3;

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0]    x0, y0, x1, y1;
    logic [COORD_W-1:0]    cur_x, cur_y;
    logic signed [EW-1:0]  dx, dy, err;
    logic                  sx_neg, sy_neg;

    logic                  xfer, at_end, step_x, step_y;
    logic signed [E2W-1:0] e2, dx_ext, dy_ext;
    logic signed [EW-1:0]  err_nxt, add_x, add_y;
    logic signed [EW-1:0]  dx_init, dy_init;

    always_comb begin
        xfer    = (state == DRAW) && pixel_ready;
        at_end  = (cur_x == x1) && (cur_y == y1);
        e2      = E2W'(err) <<< 1;
        dx_ext  = E2W'(dx);
        dy_ext  = E2W'(dy);
        step_x  = (e2 >= dy_ext);
        step_y  = (e2 <= dx_ext);
        add_x   = step_x ? dy : EW'(0);
        add_y   = step_y ? dx : EW'(0);
        // both corrections come from the same e2 and accumulate together
        err_nxt = err + add_x + add_y;
        dx_init = $signed({2'b00, abs_diff(x1, x0)});
        dy_init = -$signed({2'b00, abs_diff(y1, y0)});
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pixel       = '0;
        pixel_valid = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = INIT;
            INIT: state_nxt = DRAW;
            DRAW: begin
                pixel_valid = 1'b1;
                pixel.x     = cur_x;
                pixel.y     = cur_y;
                if (xfer && at_end) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            x0     <= '0;
            y0     <= '0;
            x1     <= '0;
            y1     <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x0 <= p.x;
                    y0 <= p.y;
                    x1 <= q.x;
                    y1 <= q.y;
                end
                INIT: begin
                    dx     <= dx_init;
                    dy     <= dy_init;
                    err    <= dx_init + dy_init;
                    sx_neg <= !(x0 < x1);
                    sy_neg <= !(y0 < y1);
                    cur_x  <= x0;
                    cur_y  <= y0;
                end
                DRAW: if (xfer && !at_end) begin
                    err <= err_nxt;
                    if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                    if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bresenham_line.md
BRESENHAM_LINE -- requirements
Module: bresenham_line

Interface
REQ-001 Parameters: none; all widths come from package constant COORD_W (default 10), the coordinate bit width.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 n_rst  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request to draw the line p->q; sampled only in IDLE.
REQ-005 p  in  Point2D  line start point (x,y unsigned COORD_W each).
REQ-006 q  in  Point2D  line end point.
REQ-007 pixel  out  Point2D  current pixel coordinate.
REQ-008 pixel_valid  out  1  pixel holds a pixel to be written.
REQ-009 pixel_ready  in  1  downstream accepts pixel; transfer occurs when pixel_valid and pixel_ready are both 1.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 done  out  1  one-cycle pulse after the final pixel is transferred; drives the rasterizer controller's bresen_done.

Function
REQ-012 States SHALL be IDLE, INIT, DRAW, DONE.
REQ-013 IDLE->INIT on start=1; p and q are latched into x0/y0/x1/y1 in that same edge.
REQ-014 INIT (1 cycle) SHALL compute: dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x0<x1 else -1, sy=+1 if y0<y1 else -1, err=dx+dy, cur=(x0,y0); then go to DRAW.
REQ-015 Error terms SHALL be signed COORD_W+2 bits, and e2=2*err signed COORD_W+3 bits; no overflow for any coordinates in range.
REQ-016 In DRAW, pixel_valid=1 and pixel=cur.
REQ-017 On transfer with cur==(x1,y1): go to DONE, with no further pixel.
REQ-018 On transfer otherwise: e2=2*err; if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy. Both updates apply in the same cycle, and err accumulates both terms.
REQ-019 Without a transfer (pixel_ready=0), pixel, pixel_valid and all internal state SHALL hold stable.
REQ-020 DONE (1 cycle): done=1, then IDLE.
REQ-021 Latency: start at cycle 0 gives first pixel_valid at cycle 2. At full throughput, N pixels occupy cycles 2..N+1 and done is at cycle N+2.
REQ-022 Pixel count SHALL be max(dx,|dy|)+1, endpoints inclusive. p==q emits exactly one pixel.
REQ-023 start while busy SHALL be ignored and not queued. A new start is accepted in the IDLE cycle following DONE.
REQ-024 Outside DRAW, pixel_valid=0 and pixel=(0,0). done=0 except in DONE.

Reset
REQ-025 n_rst=0 at a clock edge SHALL force IDLE and clear all registers to 0, including mid-line, with no done pulse. Outputs read pixel_valid=0, done=0, busy=0, pixel=(0,0).
REQ-026 The first start accepted after reset release behaves identically to the first start after power-up.

Structure
REQ-027 COORD_W and Point2D (packed struct x,y of COORD_W bits) SHALL live in defines_package, shared with the rasterizer controller.
REQ-028 No sub-module: single module, one state register plus a datapath of delta, sign and error logic.
REQ-029 The state enum SHALL be local to the module.

Verification
REQ-030 Horizontal line: start, p=(0,0), q=(4,0), pixel_ready=1 -> pixels (0,0)..(4,0) on cycles 2-6, done on cycle 7.
REQ-031 Steep reversed line: p=(3,5), q=(1,0) -> exact sequence (3,5),(3,4),(2,3),(2,2),(1,1),(1,0), then done.
REQ-032 Degenerate line: p=q=(7,7) -> one pixel (7,7) on cycle 2, done on cycle 3.
REQ-033 Backpressure: line (0,0)->(3,3) with pixel_ready toggled 1,0,0,1,... -> pixel holds during stalls; sequence (0,0),(1,1),(2,2),(3,3) with no loss or duplicate.
REQ-034 Start while busy: start pulsed again during DRAW -> ignored; exactly one done.
REQ-035 Reset and extremes: n_rst=0 mid-line -> IDLE next edge with outputs zero and no done. Line (0,0)->(1023,1023) -> 1024 pixels, last pixel (1023,1023).
